// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Runs the host side of a write: it inhibits the clock, issues a request-to-send,
// shifts out a framed byte (data, odd parity, stop) on device clock falling
// edges, and checks the device acknowledge. It reports done, or an error
// with a code. Both pad lines are open-drain: an *_oe of 1 pulls the line low.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES   = 10000,
  parameter int unsigned RTS_CYCLES       = 200,
  parameter int unsigned RESPONSE_TIMEOUT = 1500000,
  parameter int unsigned PACKET_TIMEOUT   = 200000,
  parameter int unsigned FILTER_LEN       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQUEST, SEND, ACK_WAIT, RECOVER
  } state_t;

  state_t        state;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic [FW-1:0] filt_cnt;
  logic          clk_filt, clk_filt_d;
  logic          fall;
  logic [31:0]   cnt;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic          nack;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = clk_filt_d & ~clk_filt;

  // Two-flop synchronizers. The idle bus is high, so reset to 1 to avoid a
  // spurious edge when the device clock is sampled for the first time.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  // Clock level changes only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Transfer sequencer. The single counter holds the phase length during
  // inhibit/request and the active timeout during the send and ack phases.
  // While it is waiting for the device to respond, the counter starts at 1
  // on the arming edge. Expiry therefore lands exactly N cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      err_code    <= 2'b00;
      cnt         <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      nack        <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_start) begin
            shreg       <= {1'b1, ~^tx_data, tx_data};
            cnt         <= 32'd1;
            bit_cnt     <= '0;
            nack        <= 1'b0;
            err_code    <= 2'b00;
            tx_busy     <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            state       <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INHIBIT_CYCLES) begin
            ps2_data_oe <= 1'b1;
            cnt         <= 32'd1;
            state       <= REQUEST;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        REQUEST: begin
          if (cnt == RTS_CYCLES) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= 32'd1;
            state      <= SEND;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SEND, ACK_WAIT: begin
          if ((bit_cnt == 4'd0 && cnt == RESPONSE_TIMEOUT) ||
              (bit_cnt != 4'd0 && cnt == PACKET_TIMEOUT)) begin
            // Abort: free the bus immediately and skip the recovery wait.
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            err_code    <= (bit_cnt == 4'd0) ? 2'b01 : 2'b10;
            tx_busy     <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
            if (fall) begin
              if (state == SEND) begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= {1'b0, shreg[9:1]};
                bit_cnt     <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd0) cnt <= 32'd1;
                if (bit_cnt == 4'd9) state <= ACK_WAIT;
              end else begin
                nack  <= data_s;
                state <= RECOVER;
              end
            end
          end
        end
        RECOVER: begin
          if (clk_filt && data_s) begin
            tx_busy <= 1'b0;
            state   <= IDLE;
            if (nack) begin
              tx_error <= 1'b1;
              err_code <= 2'b11;
            end else begin
              tx_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus, behavioural keyboard model, and a
// scoreboard of expected completions checked by an independent monitor.
module tb_ps2_host_tx;
  localparam int INH = 20, RTS = 4, RSP = 500, PKT = 2000, HALF = 40;

  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;
  logic [1:0] err_code;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .RESPONSE_TIMEOUT(RSP),
    .PACKET_TIMEOUT(PKT), .FILTER_LEN(8)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_error(tx_error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0, n_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // tkind: 0 no timing check, 1 response timeout, 2 packet timeout
  typedef struct {
    logic       is_err;
    logic [1:0] code;
    logic       chk_frame;
    logic [9:0] frame;
    int         tkind;
  } exp_t;
  exp_t sb[$];

  // ---------------- device model ----------------
  // modes: 0 ACK, 1 never clocks, 2 NACK, 3 stop after edge 5
  int         dev_mode = 0;
  logic       dev_glitch = 1'b0;
  logic [9:0] dev_rx = '0;
  int         dev_edges = 0;
  logic       dev_busy = 1'b0;

  initial begin : device
    forever begin
      while (ps2_clk_in !== 1'b0) @(negedge clk);
      while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0)) @(negedge clk);
      if (dev_mode != 1) begin
        dev_busy = 1'b1;
        dev_edges = 0;
        dev_rx = '0;
        repeat (50) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
          if (dev_mode == 3 && i == 6) break;
          if (i == 11 && dev_mode == 0) dev_data_low = 1'b1;
          dev_edges = i;
          dev_clk_low = 1'b1;
          repeat (HALF) @(negedge clk);
          if (i <= 10) dev_rx[i-1] = ps2_data_in;
          dev_clk_low = 1'b0;
          if (dev_glitch && i == 3) begin
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (3) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF - 13) @(negedge clk);
          end else begin
            repeat (HALF) @(negedge clk);
          end
        end
        dev_data_low = 1'b0;
        dev_busy = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic p_clk_oe = 1'b0, p_data_oe = 1'b0, d1_armed = 1'b0;
  int   t_clk_rise = 0, t_data_rise = 0, t_clk_fall = 0, t_d1 = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!p_clk_oe && ps2_clk_oe) t_clk_rise = cyc;
      if (!p_data_oe && ps2_data_oe) t_data_rise = cyc;
      if (p_clk_oe && !ps2_clk_oe && tx_busy) begin
        t_clk_fall = cyc;
        d1_armed = 1'b1;
        check("inhibit_len", 32'(t_data_rise - t_clk_rise), INH);
        check("rts_len", 32'(cyc - t_data_rise), RTS);
      end
      if (d1_armed && p_data_oe && !ps2_data_oe) begin
        t_d1 = cyc;
        d1_armed = 1'b0;
      end
      if (tx_done || tx_error) begin
        n_pulses++;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse: done=%b error=%b expected no pulse", tx_done, tx_error);
        end else begin
          e = sb.pop_front();
          check("done", 32'(tx_done), 32'(!e.is_err));
          check("error", 32'(tx_error), 32'(e.is_err));
          if (e.is_err) check("err_code", 32'(err_code), 32'(e.code));
          check("oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
          check("busy_low", 32'(tx_busy), 32'd0);
          if (e.chk_frame) check("frame", 32'(dev_rx), 32'(e.frame));
          if (e.tkind == 1) check("resp_timeout", 32'(cyc - t_clk_fall), RSP);
          if (e.tkind == 2) check("pkt_timeout", 32'(cyc - t_d1), PKT);
        end
      end
      p_clk_oe = ps2_clk_oe;
      p_data_oe = ps2_data_oe;
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_tx(input logic [7:0] d);
    @(posedge clk); #1;
    tx_data = d;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    tx_data = 8'h5A;
    check("accept_busy", 32'(tx_busy), 32'd1);
    check("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
  endtask

  task automatic wait_result(input int bound);
    int start = n_pulses;
    int k = 0;
    while (n_pulses == start && k < bound) begin
      @(posedge clk);
      k++;
    end
    if (n_pulses == start) begin
      n_checks++;
      n_errors++;
      $display("FAIL result_wait: no done/error within %0d cycles", bound);
    end
  endtask

  task automatic wait_dev(input int edges, input int bound);
    int k = 0;
    while (dev_edges < edges && k < bound) begin
      @(posedge clk);
      k++;
    end
    if (dev_edges < edges) begin
      n_checks++;
      n_errors++;
      $display("FAIL dev_edge_wait: reached %0d edges, needed %0d", dev_edges, edges);
    end
  endtask

  task automatic wait_dev_idle(input int bound);
    int k = 0;
    while (dev_busy && k < bound) begin
      @(posedge clk);
      k++;
    end
    if (dev_busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL dev_idle_wait: device still busy after %0d cycles", bound);
    end
    repeat (5) @(posedge clk);
  endtask

  initial begin : main
    repeat (3) @(posedge clk); #1;
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_error", 32'(tx_error), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // 0xED, ACK: frame {stop 1, parity 1, ED}
    dev_mode = 0;
    sb.push_back('{1'b0, 2'b00, 1'b1, 10'h3ED, 0});
    start_tx(8'hED);
    wait_result(5000);
    wait_dev_idle(2000);

    // 0x07, ACK, with a short glitch on the clock: parity 0
    dev_mode = 0;
    dev_glitch = 1'b1;
    sb.push_back('{1'b0, 2'b00, 1'b1, 10'h207, 0});
    start_tx(8'h07);
    wait_result(5000);
    wait_dev_idle(2000);
    dev_glitch = 1'b0;

    // device never clocks: response timeout
    dev_mode = 1;
    sb.push_back('{1'b1, 2'b01, 1'b0, 10'h000, 1});
    start_tx(8'hAA);
    wait_result(5000);

    // NACK on 0xF4 (five ones, parity 0)
    dev_mode = 2;
    sb.push_back('{1'b1, 2'b11, 1'b1, 10'h2F4, 0});
    start_tx(8'hF4);
    wait_result(5000);
    wait_dev_idle(2000);
    check("err_code_held", 32'(err_code), 32'd3);

    // device stops after edge 5: packet timeout; a second start is ignored
    dev_mode = 3;
    dev_edges = 0;
    sb.push_back('{1'b1, 2'b10, 1'b0, 10'h000, 2});
    start_tx(8'hED);
    wait_dev(2, 2000);
    @(posedge clk); #1;
    tx_data = 8'h00;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    check("ignored_start_busy", 32'(tx_busy), 32'd1);
    check("ignored_start_clk_oe", 32'(ps2_clk_oe), 32'd0);
    wait_result(5000);
    check("partial_frame", 32'(dev_rx[4:0]), 32'h0D);
    wait_dev_idle(2000);

    // reset mid-SEND after edge 4, then a fresh 0xFF completes
    dev_mode = 0;
    dev_edges = 0;
    start_tx(8'h3C);
    wait_dev(4, 2000);
    repeat (20) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_mid_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_mid_busy", 32'(tx_busy), 32'd0);
    check("rst_mid_pulses", 32'({tx_done, tx_error}), 32'd0);
    wait_dev_idle(2000);
    sb.push_back('{1'b0, 2'b00, 1'b1, 10'h3FF, 0});
    start_tx(8'hFF);
    wait_result(5000);
    wait_dev_idle(2000);

    repeat (10) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d expected results never seen", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
